// File: rtl/fb_rect_fill_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_rect_fill_if
// Description : Command and pixel-write handshake bundle for fb_rect_fill.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_rect_fill_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int ADDR_W = 19,
    parameter int PIX_W  = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x;
    logic [Y_W-1:0]    cmd_y;
    logic [X_W-1:0]    cmd_w;
    logic [Y_W-1:0]    cmd_h;
    logic              cmd_mode;
    logic [PIX_W-1:0]  cmd_color;
    logic [PIX_W-1:0]  cmd_color2;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_mode, cmd_color, cmd_color2,
        output wr_ready,
        input  cmd_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_mode, cmd_color, cmd_color2,
        input  wr_ready,
        output cmd_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : fb_rect_fill
// Description : Rectangle-fill write engine (solid / checkerboard) for the
//               video RAM write port. Define FB_RECT_CLIP_EN to clip to screen.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rect_fill #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int ADDR_W    = 19,
    parameter int PIX_W     = 12,
    parameter int CHK_SHIFT = 3
) (
    input  logic           clk,
    input  logic           rstn,
    fb_rect_fill_if.slave  bus,
    output logic           busy,
    output logic           done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(WIDTH);

    if (HEIGHT > (1 << Y_W) || CHK_SHIFT >= Y_W) begin : g_bad_geometry
        $error("fb_rect_fill: HEIGHT or CHK_SHIFT does not fit the Y_W field");
    end

    logic [1:0]        r_state;
    logic [X_W-1:0]    r_x, r_w, r_cx, r_ax;
    logic [Y_W-1:0]    r_y, r_h, r_cy, r_ay;
    logic              r_mode;
    logic [PIX_W-1:0]  r_c1, r_c2;
    logic [ADDR_W-1:0] r_row, r_addr;

    logic [X_W-1:0]    w_eff_w;
    logic [Y_W-1:0]    w_eff_h;
    logic [ADDR_W-1:0] w_row0;
    logic              w_row_end, w_last, w_chk;

`ifdef FB_RECT_CLIP_EN
    always_comb begin
        w_eff_w = r_w;
        w_eff_h = r_h;
        if (32'(r_x) >= 32'(WIDTH) || 32'(r_y) >= 32'(HEIGHT)) begin
            w_eff_w = '0;
        end else begin
            if (32'(r_w) > 32'(WIDTH) - 32'(r_x))
                w_eff_w = X_W'(32'(WIDTH) - 32'(r_x));
            if (32'(r_h) > 32'(HEIGHT) - 32'(r_y))
                w_eff_h = Y_W'(32'(HEIGHT) - 32'(r_y));
        end
    end
`else
    assign w_eff_w = r_w;
    assign w_eff_h = r_h;
`endif

    // The only multiply: start-of-rectangle row base; later rows step by WIDTH.
    assign w_row0    = ADDR_W'(32'(r_y) * 32'(WIDTH));
    assign w_row_end = (r_cx == r_w - X_W'(1));
    assign w_last    = w_row_end && (r_cy == r_h - Y_W'(1));
    assign w_chk     = r_ax[CHK_SHIFT] ^ r_ay[CHK_SHIFT];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_w     <= '0;
            r_h     <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_ax    <= '0;
            r_ay    <= '0;
            r_mode  <= 1'b0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_row   <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_x     <= bus.cmd_x;
                        r_y     <= bus.cmd_y;
                        r_w     <= bus.cmd_w;
                        r_h     <= bus.cmd_h;
                        r_mode  <= bus.cmd_mode;
                        r_c1    <= bus.cmd_color;
                        r_c2    <= bus.cmd_color2;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_w     <= w_eff_w;
                    r_h     <= w_eff_h;
                    r_cx    <= '0;
                    r_cy    <= '0;
                    r_ax    <= r_x;
                    r_ay    <= r_y;
                    r_row   <= w_row0;
                    r_addr  <= w_row0 + ADDR_W'(r_x);
                    r_state <= (w_eff_w == '0 || w_eff_h == '0) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (bus.wr_ready) begin
                        if (w_row_end) begin
                            r_cx   <= '0;
                            r_cy   <= r_cy + Y_W'(1);
                            r_ax   <= r_x;
                            r_ay   <= r_ay + Y_W'(1);
                            r_row  <= r_row + c_ROW_STEP;
                            r_addr <= r_row + c_ROW_STEP + ADDR_W'(r_x);
                            if (w_last)
                                r_state <= S_DONE;
                        end else begin
                            r_cx   <= r_cx + X_W'(1);
                            r_ax   <= r_ax + X_W'(1);
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.wr_en     = (r_state == S_RUN);
    assign bus.wr_addr   = (r_state == S_RUN) ? r_addr : '0;
    assign bus.wr_data   = (r_state != S_RUN) ? '0 : ((r_mode && w_chk) ? r_c2 : r_c1);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_rect_fill
// Description : Self-checking bench for fb_rect_fill (vector table + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_rect_fill;
    localparam int WIDTH = 640, HEIGHT = 480, X_W = 10, Y_W = 9;
    localparam int ADDR_W = 19, PIX_W = 12, CHK_SHIFT = 3;
    localparam int BOUND = 3000;

    typedef struct {
        int x, y, w, h, mode, c1, c2, stall;
        int exp_n, exp_a0, exp_alast, exp_d0;
    } vec_t;
    typedef struct { int addr; int data; } wr_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic busy, done;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];
    wr_t  exp_q[$], got_q[$];

    always #5 clk = ~clk;

    fb_rect_fill_if #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W), .PIX_W(PIX_W)) bus ();

    fb_rect_fill #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W),
                   .ADDR_W(ADDR_W), .PIX_W(PIX_W), .CHK_SHIFT(CHK_SHIFT))
        dut (.clk(clk), .rstn(rstn), .bus(bus), .busy(busy), .done(done));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference: the list of writes a command must produce, row-major.
    task automatic model(input vec_t v);
        int ew, eh, ax, ay;
        ew = v.w;
        eh = v.h;
`ifdef FB_RECT_CLIP_EN
        if (v.x >= WIDTH || v.y >= HEIGHT) ew = 0;
        else begin
            if (ew > WIDTH - v.x)  ew = WIDTH - v.x;
            if (eh > HEIGHT - v.y) eh = HEIGHT - v.y;
        end
`endif
        exp_q.delete();
        if (ew == 0) eh = 0;
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++) begin
                ax = v.x + c;
                ay = v.y + r;
                exp_q.push_back('{((ay * WIDTH) + ax) % (1 << ADDR_W),
                                  (v.mode != 0 && (((ax ^ ay) >> CHK_SHIFT) & 1) == 1) ? v.c2 : v.c1});
            end
    endtask

    task automatic run_cmd(input vec_t v);
        int first_wr = -1, last_acc = -1, done_cyc = -1, n;
        logic held = 1'b0;
        logic [31:0] h_a = '0, h_d = '0;
        model(v);
        n = exp_q.size();
        got_q.delete();
        @(negedge clk);
        bus.cmd_x = X_W'(v.x);  bus.cmd_y = Y_W'(v.y);
        bus.cmd_w = X_W'(v.w);  bus.cmd_h = Y_W'(v.h);
        bus.cmd_mode = v.mode[0];
        bus.cmd_color = PIX_W'(v.c1); bus.cmd_color2 = PIX_W'(v.c2);
        bus.cmd_valid = 1'b1;
        bus.wr_ready = 1'b1;
        chk("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= BOUND; k++) begin
            if (k > 1) @(negedge clk);
            case (v.stall)
                0:       bus.wr_ready = 1'b1;
                1:       bus.wr_ready = k[0];
                default: bus.wr_ready = 1'($urandom_range(0, 1));
            endcase
            if (held) begin
                chk("stall_addr_hold", 32'(bus.wr_addr), h_a);
                chk("stall_data_hold", 32'(bus.wr_data), h_d);
            end
            held = 1'b0;
            if (bus.wr_en === 1'b1) begin
                if (first_wr < 0) first_wr = k;
                if (bus.wr_ready) begin
                    got_q.push_back('{int'(bus.wr_addr), int'(bus.wr_data)});
                    last_acc = k;
                end else begin
                    held = 1'b1;
                    h_a = 32'(bus.wr_addr);
                    h_d = 32'(bus.wr_data);
                end
            end
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
        end
        if (done_cyc < 0) chk("timeout_done", 0, 1);
        chk("n_writes", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            chk("wr_addr", got_q[i].addr, exp_q[i].addr);
            chk("wr_data", got_q[i].data, exp_q[i].data);
        end
        chk("done_after_last", done_cyc, (n == 0) ? 2 : last_acc + 1);
        if (n > 0) chk("first_wr_latency", first_wr, 2);
        if (v.stall == 0) chk("done_latency", done_cyc, n + 2);
        if (v.exp_n >= 0) begin
            chk("tbl_n", got_q.size(), v.exp_n);
            if (v.exp_n > 0 && got_q.size() > 0) begin
                chk("tbl_first_addr", got_q[0].addr, v.exp_a0);
                chk("tbl_last_addr", got_q[got_q.size()-1].addr, v.exp_alast);
                chk("tbl_first_data", got_q[0].data, v.exp_d0);
            end
        end
        @(negedge clk);
        chk("ready_after_done", 32'(bus.cmd_ready), 1);
        chk("idle_after_done", {busy, done, bus.wr_en}, 0);
    endtask

    initial begin
        vec_t v;
        bus.cmd_valid = 1'b1;
        bus.cmd_x = 10'd5; bus.cmd_y = 9'd5; bus.cmd_w = 10'd3; bus.cmd_h = 9'd3;
        bus.cmd_mode = 1'b0; bus.cmd_color = 12'hFFF; bus.cmd_color2 = 12'h000;
        bus.wr_ready = 1'b1;

        // Reset held with a pending command: nothing may be accepted.
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);

        tbl.push_back('{1, 1, 2, 2, 0, 'h0FF, 0, 0,       4, 641, 1282, 'h0FF});
        tbl.push_back('{1, 1, 2, 2, 0, 'h0FF, 0, 1,       4, 641, 1282, 'h0FF});
        tbl.push_back('{10, 10, 0, 5, 0, 'h111, 0, 0,     0, 0, 0, 0});
        tbl.push_back('{10, 10, 3, 0, 0, 'h111, 0, 0,     0, 0, 0, 0});
        tbl.push_back('{6, 0, 4, 1, 1, 'hF00, 'h00F, 0,   4, 6, 9, 'hF00});
        tbl.push_back('{0, 8, 16, 1, 1, 'h123, 'h456, 2,  16, 5120, 5135, 'h456});
        tbl.push_back('{639, 479, 1, 1, 0, 'hABC, 0, 0,   1, 307199, 307199, 'hABC});
`ifdef FB_RECT_CLIP_EN
        tbl.push_back('{638, 479, 10, 10, 0, 'h5A5, 0, 0, 2, 307198, 307199, 'h5A5});
        tbl.push_back('{700, 10, 5, 5, 0, 'h777, 0, 0,    0, 0, 0, 0});
`else
        tbl.push_back('{638, 479, 10, 10, 0, 'h5A5, 0, 0, 100, 307198, 312967, 'h5A5});
        tbl.push_back('{700, 10, 5, 5, 0, 'h777, 0, 0,    25, 7100, 9664, 'h777});
`endif
        foreach (tbl[i]) run_cmd(tbl[i]);

        // Reset in the middle of a long rectangle.
        @(negedge clk);
        bus.cmd_x = 10'd0; bus.cmd_y = 9'd0; bus.cmd_w = 10'd20; bus.cmd_h = 9'd5;
        bus.cmd_mode = 1'b0; bus.wr_ready = 1'b1; bus.cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_wr_en", 32'(bus.wr_en), 1);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_wr_en", 32'(bus.wr_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_ready", 32'(bus.cmd_ready), 1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_quiet", {busy, bus.wr_en, done}, 0);
        run_cmd(tbl[0]);

        for (int i = 0; i < 24; i++) begin
            v = '{int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                  int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 4095)), int'($urandom_range(0, 2)),
                  -1, 0, 0, 0};
            run_cmd(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fb_rect_fill.md
Name: fb_rect_fill

Overview:
- Parametrised framebuffer write engine; successor to the free-running single-colour fill counter.
- Accepts rectangle-fill commands over a valid/ready handshake.
- Emits one pixel write per accepted beat to the dual-port video RAM write port (port A), with write-side backpressure.
- Supports solid and checkerboard fill modes; the VGA read side is untouched.

Parameters:
WIDTH, 640, screen width in pixels (also framebuffer row stride)
HEIGHT, 480, screen height in pixels
X_W, 10, width of x coordinate / rectangle width fields
Y_W, 9, width of y coordinate / rectangle height fields
ADDR_W, 19, framebuffer address width
PIX_W, 12, pixel width (4:4:4 RGB)
CHK_SHIFT, 3, checker cell size = 2**CHK_SHIFT pixels

Ports:
clk  in  1  single clock (video RAM write clock)
rstn  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept command
cmd_x  in  X_W  rectangle left column
cmd_y  in  Y_W  rectangle top row
cmd_w  in  X_W  rectangle width in pixels
cmd_h  in  Y_W  rectangle height in pixels
cmd_mode  in  1  0 = solid, 1 = checker
cmd_color  in  PIX_W  primary colour
cmd_color2  in  PIX_W  secondary colour (checker only)
wr_en  out  1  pixel write request
wr_ready  in  1  write accepted this cycle when high with wr_en
wr_addr  out  ADDR_W  framebuffer address
wr_data  out  PIX_W  pixel value
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at command completion

Behaviour:
- Single clock domain (clk); rstn asynchronous, active-low.
- Reset (async, any state, including mid-rectangle): state=IDLE; cmd_ready=1, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. The in-flight command is abandoned and no further writes are issued.
- FSM states: IDLE, SETUP, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch all cmd_* fields and go to SETUP.
  - cmd_ready=0 in all other states.
- SETUP (1 cycle):
  - Apply clipping (see Optional Feature).
  - Compute row_base = y*WIDTH (this is the only multiply); set cur_x=0, cur_y=0.
  - If effective w==0 or h==0, go to DONE with no writes; otherwise go to RUN.
- RUN:
  - wr_en=1.
  - wr_addr = row_base + x0 + cur_x, truncated to ADDR_W; computed incrementally, no multiplier.
  - wr_data: mode 0 gives color. Mode 1 gives color when ((x0+cur_x) ^ (y0+cur_y)) bit CHK_SHIFT is 0, else color2. The checker uses absolute screen coordinates.
  - Advance only on wr_en&wr_ready.
    - cur_x++.
    - At cur_x==w-1: cur_x=0, cur_y++, row_base+=WIDTH.
  - While wr_ready=0, wr_addr and wr_data hold stable.
  - Accepting the last pixel (cur_x==w-1, cur_y==h-1) goes to DONE. wr_en deasserts the following cycle.
- DONE: done=1 for exactly one cycle, wr_en=0, then IDLE.
- Latency:
  - First wr_en is 2 cycles after the accept edge.
  - With wr_ready held high, exactly w*h writes occur on consecutive cycles.
  - done is asserted the cycle after the last write.
  - Minimum command-to-command spacing is w*h+3 cycles.
- Writes follow row-major order, top-left first.
- cmd_valid asserted while busy is ignored; the command must be held until cmd_ready.

Optional Feature:
- Macro: FB_RECT_CLIP_EN.
- Defined: in SETUP, rectangles are clipped to the screen.
  - x0>=WIDTH or y0>=HEIGHT forces effective w=0 (no writes, done still pulses).
  - Otherwise w=min(w, WIDTH-x0) and h=min(h, HEIGHT-y0).
- Undefined: no clipping.
  - Coordinates are used as given, and the address wraps modulo 2**ADDR_W.
  - Keeping commands in bounds is the caller's responsibility.

Test Plan:
- Reset: hold rstn=0 with cmd_valid=1 -> cmd_ready=1, wr_en=0, busy=0, done=0; no accept until rstn=1.
- Solid fill: x=1, y=1, w=2, h=2, color=0x0FF, wr_ready=1 -> writes to addr 641, 642, 1281, 1282, all data 0x0FF, on 4 consecutive cycles; done one cycle after the last write.
- Backpressure: same command with wr_ready low every other cycle -> same 4 address/data pairs, each held stable while stalled; no duplicates or skips.
- Zero size: w=0, h=5 -> no wr_en; done pulses 2 cycles after accept; cmd_ready returns.
- Checker: x=6, y=0, w=4, h=1, mode=1, color=0xF00, color2=0x00F, CHK_SHIFT=3 -> data F00, F00, 00F, 00F at addr 6..9.
- Clip (FB_RECT_CLIP_EN): x=638, y=479, w=10, h=10 -> exactly 2 writes, addr 307198 and 307199. Also reset mid-RUN -> wr_en drops immediately, and the next command starts clean.
